// File: rtl/sha256_msg_schedule_pkg.sv
// Shared constants and types for the SHA-256 message-schedule stage.
package sha256_msg_schedule_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 512;
    localparam int unsigned WIN_N      = 16;
    localparam int unsigned ROUNDS_DEF = 64;

    // small sigma0: ROTR7 ^ ROTR18 ^ SHR3
    localparam int unsigned S0_R1 = 7;
    localparam int unsigned S0_R2 = 18;
    localparam int unsigned S0_S  = 3;

    // small sigma1: ROTR17 ^ ROTR19 ^ SHR10
    localparam int unsigned S1_R1 = 17;
    localparam int unsigned S1_R2 = 19;
    localparam int unsigned S1_S  = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rotr.sv
// Rotate right by a fixed amount N (0 < N < W).
module rotr #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 1
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = (a >> N) | (a << (W - N));

endmodule

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(S).
module sha256_small_sigma
    import sha256_msg_schedule_pkg::*;
#(
    parameter int unsigned R1 = 7,
    parameter int unsigned R2 = 18,
    parameter int unsigned S  = 3
) (
    input  logic [31:0] x,
    output logic [31:0] y
);

    word_t r1, r2, s;

    rotr #(.W(WORD_W), .N(R1)) u_rotr1 (.a(x), .y(r1));
    rotr #(.W(WORD_W), .N(R2)) u_rotr2 (.a(x), .y(r2));
    shr  #(.W(WORD_W), .N(S))  u_shr   (.a(x), .y(s));

    assign y = r1 ^ r2 ^ s;

endmodule

// File: rtl/shr.sv
// Zero-fill logical shift right by a fixed amount N.
module shr #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 1
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = a >> N;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block into a 16-word sliding
// window and streams W0..W(ROUNDS-1), one word per next handshake.
module sha256_msg_schedule
    import sha256_msg_schedule_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block,
    input  logic         next,
    output logic [31:0]  w,
    output logic [5:0]   t,
    output logic         w_valid,
    output logic         busy,
    output logic         done
);

    state_t     state, state_d;
    word_t      win [WIN_N];
    logic [5:0] t_q;
    logic       done_q;
    logic       load, adv, last;
    word_t      s0, s1, new_w;

    sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .S(S0_S)) u_sigma0 (.x(win[1]),  .y(s0));
    sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .S(S1_S)) u_sigma1 (.x(win[14]), .y(s1));

    // W(t+16) from the current window; sum wraps modulo 2^32
    assign new_w = s1 + win[9] + s0 + win[0];

    // next-state and handshake decode
    always_comb begin
        state_d = state;
        load    = 1'b0;
        adv     = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (next) begin
                    adv = 1'b1;
                    if (t_q == 6'(ROUNDS - 1)) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // sliding window: parallel load on start, shift-and-append on next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WIN_N; i++) win[i] <= '0;
        end else if (load) begin
            for (int unsigned i = 0; i < WIN_N; i++) win[i] <= block[BLOCK_W-1-WORD_W*i -: WORD_W];
        end else if (adv) begin
            for (int unsigned i = 0; i < WIN_N-1; i++) win[i] <= win[i+1];
            win[WIN_N-1] <= new_w;
        end
    end

    // word index and end-of-block pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (load)     t_q <= '0;
            else if (adv) t_q <= t_q + 6'd1;
        end
    end

    assign w       = win[0];
    assign t       = t_q;
    assign w_valid = (state == RUN);
    assign busy    = (state == RUN);
    assign done    = done_q;

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- SHA-256 message-schedule stage; directly consumes the logical-shift primitive (shr with N=3 and N=10) inside the small-sigma functions.
- Accepts one 512-bit padded message block and streams the 64 schedule words W0..W63 to the compression round, one word per handshake.
- Uses a 16-word sliding window, so the whole 64-word schedule is never stored.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block; legal range 17..64; ROUNDS<64 is for test only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  load request; sampled only in IDLE
- block  input  512  message block; block[511:480] is W0, block[31:0] is W15
- next  input  1  consumer has taken the current w; advances the schedule
- w  output  32  current schedule word W_t
- t  output  6  index of current word
- w_valid  output  1  w and t are valid
- busy  output  1  block in progress (RUN state)
- done  output  1  one-cycle pulse after W_(ROUNDS-1) is consumed

Behaviour:
- Reset: asynchronous. State goes to IDLE. Window words, w, t, w_valid, busy and done are all cleared to 0.
- States: IDLE and RUN.
- IDLE with start=1: load the window with win[i] = block[511-32i -: 32] for i = 0..15. Set t=0 and go to RUN.
  - Latency: w_valid=1 and w=W0 on the cycle after start is sampled.
- RUN outputs: w = win[0], w_valid=1, busy=1.
- RUN with next=1: shift the window, win[i] <= win[i+1] for i = 0..14. Set win[15] to the new word:
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^32 (carries discarded).
  - This equals W_(t+16).
  - t <= t+1.
- sigma0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- SHR is a zero-fill logical shift; ROTR is a rotate right.
- RUN with next=0: window, w and t hold. The stage is fully stallable with no word loss.
- RUN with next=1 and t==ROUNDS-1: go to IDLE. On the following cycle done=1 for exactly one cycle, and w_valid=0, busy=0.
- Words generated past W63 are never emitted. Extra window computation is harmless.
- start during RUN is ignored; no queuing.
- start in the same cycle as the done pulse (state already IDLE) is accepted. Back-to-back blocks therefore cost one bubble cycle.
- next while w_valid=0 is ignored.
- block is sampled only in the load cycle and may change freely afterwards.
- Reset during RUN aborts the block immediately with no done pulse. The next start begins cleanly at t=0.
- No combinational path from start or next to any output; all outputs are registered.

Decomposition:
- Shared include sha256_defs.vh: word width (32), block width (512), ROUNDS default, and the sigma shift/rotate amounts (7/18/3 and 17/19/10) as named constants.
- One sub-module: sha256_small_sigma, parameterised by R1, R2, S.
  - Built from two rotate-right instances and one shr instance with N=S, XORed together.
  - Instantiate twice: sigma0 (7,18,3) and sigma1 (17,19,10).
- A rotr module is added alongside shr with the same parameter-N style if not already present.

Test Plan:
- "abc" block (word0=61626380, words1..14=0, word15=00000018), start, next held high -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W63=12B1EDEB. done pulses once, 65 cycles after load acceptance.
- All-zero block, next held high -> all 64 words are 00000000, t counts 0..63, done pulse on the cycle after t=63 is consumed.
- "abc" block, next toggled pseudo-randomly -> sequence identical to scenario 1; w and t stable in every cycle with next=0.
- start pulsed at t=20 with a different block -> ignored; output continues the first block's sequence unchanged.
- Assert rst at t=30 -> all outputs 0 in the same cycle with no done pulse. A new "abc" start then gives W0=61626380 at t=0.
- start asserted in the done-pulse cycle with an all-ones block -> accepted; next cycle w=FFFFFFFF, t=0, w_valid=1.
